// File: rtl/pwm_burst_sched.sv
// pwm_burst_sched: burst-table sequencer driving the half-bridge dead-time PWM core.
// Optional WAIT-state watchdog is enabled by defining PWM_SCHED_WDOG_EN.
module pwm_burst_sched #(
    parameter int _RAM_WIDTH  = 32,
    parameter int ADDR_W      = 2,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  loop_en,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [_RAM_WIDTH-1:0] cfg_pulse_period,
    input  logic [_RAM_WIDTH-1:0] cfg_die_period,
    input  logic [CNT_W-1:0]      cfg_count,
    input  logic                  cfg_last,
    input  logic                  pwm_done,
    output logic [_RAM_WIDTH-1:0] pulse_period,
    output logic [_RAM_WIDTH-1:0] die_period,
    output logic                  pwm_en,
    output logic                  pwm_dis,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     cur_entry
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_NEXT} state_t;

    state_t                r_state, w_next;
    logic [_RAM_WIDTH-1:0] r_tbl_pp   [DEPTH];
    logic [_RAM_WIDTH-1:0] r_tbl_dp   [DEPTH];
    logic [CNT_W-1:0]      r_tbl_cnt  [DEPTH];
    logic                  r_tbl_last [DEPTH];
    logic [CNT_W-1:0]      r_remaining;
    logic                  r_done_q;
    logic                  r_pwm_en, r_pwm_dis, r_busy, r_done;
    logic [ADDR_W-1:0]     r_cur_entry;
    logic [_RAM_WIDTH-1:0] r_pulse_period, r_die_period;
    logic                  w_accept, w_tail, w_done_set, w_wdog_trip;

    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_tail   = r_tbl_last[r_cur_entry] || (r_cur_entry == ADDR_W'(DEPTH - 1));

`ifdef PWM_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;

    // A pulse completion arriving on the trip cycle takes precedence over the timeout.
    assign w_wdog_trip = (r_state == S_WAIT) && !r_done_q &&
                         (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_FIRE)
                r_wdog <= '0;
            else if (r_state == S_WAIT)
                r_wdog <= r_wdog + 1'b1;
            if (w_accept)
                r_err <= 1'b0;
            else if (w_wdog_trip && !abort)
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_wdog_trip = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: w_next = (r_tbl_cnt[r_cur_entry] == '0) ? S_NEXT : S_FIRE;
            S_FIRE: w_next = S_WAIT;
            S_WAIT: begin
                if (r_done_q)
                    w_next = (r_remaining == CNT_W'(1)) ? S_NEXT : S_FIRE;
                else if (w_wdog_trip)
                    w_next = S_IDLE;
            end
            S_NEXT: begin
                if (!w_tail || loop_en) begin
                    w_next = S_LOAD;
                end else begin
                    w_next     = S_IDLE;
                    w_done_set = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next     = S_IDLE;
            w_done_set = 1'b0;
        end
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl_pp[i]   <= '0;
                r_tbl_dp[i]   <= '0;
                r_tbl_cnt[i]  <= '0;
                r_tbl_last[i] <= 1'b0;
            end
        end else if (cfg_we && !r_busy) begin
            r_tbl_pp[cfg_addr]   <= cfg_pulse_period;
            r_tbl_dp[cfg_addr]   <= cfg_die_period;
            r_tbl_cnt[cfg_addr]  <= cfg_count;
            r_tbl_last[cfg_addr] <= cfg_last;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            r_pwm_en       <= 1'b0;
            r_pwm_dis      <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_done_q       <= 1'b0;
            r_remaining    <= '0;
            r_cur_entry    <= '0;
            r_pulse_period <= '0;
            r_die_period   <= '0;
        end else begin
            r_pwm_en <= (w_next == S_FIRE);
            r_busy   <= (w_next != S_IDLE);
            r_done   <= w_done_set;
            if (w_next == S_IDLE)
                r_pwm_dis <= 1'b1;
            else if (w_next == S_FIRE)
                r_pwm_dis <= 1'b0;
            r_done_q <= pwm_done && (r_state == S_WAIT);
            if (r_state == S_LOAD) begin
                r_pulse_period <= r_tbl_pp[r_cur_entry];
                r_die_period   <= r_tbl_dp[r_cur_entry];
                r_remaining    <= r_tbl_cnt[r_cur_entry];
            end else if (r_state == S_WAIT && r_done_q) begin
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_accept)
                r_cur_entry <= '0;
            else if (r_state == S_NEXT && !abort && w_tail && loop_en)
                r_cur_entry <= '0;
            else if (r_state == S_NEXT && !abort && !w_tail)
                r_cur_entry <= r_cur_entry + 1'b1;
        end
    end

    assign pulse_period = r_pulse_period;
    assign die_period   = r_die_period;
    assign pwm_en       = r_pwm_en;
    assign pwm_dis      = r_pwm_dis;
    assign busy         = r_busy;
    assign done         = r_done;
    assign cur_entry    = r_cur_entry;
endmodule
